// File: rtl/fifo_axis_tx.sv
// fifo_axis_tx: drains a first-word-fall-through FIFO into an AXI-Stream
// master packet of programmable length, with a fully registered output.
module fifo_axis_tx #(
    parameter int WIDTH    = 32,
    parameter int LEN_BITS = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fifo_empty,
    input  logic [WIDTH-1:0]    fifo_data,
    output logic                fifo_r_ready,
    input  logic                cfg_start,
    input  logic [LEN_BITS-1:0] cfg_len,
    output logic                busy,
    output logic                done,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [WIDTH-1:0]    m_axis_tdata,
    output logic                m_axis_tlast
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [LEN_BITS-1:0] rem;
    logic [LEN_BITS-1:0] rem_n;
    logic                done_n;
    logic                pop;
    logic                hs;
    logic                rem_one;

    // The output slot can be refilled when empty or emptying this edge.
    assign fifo_r_ready = (state == RUN) && (!m_axis_tvalid || m_axis_tready);
    assign pop          = fifo_r_ready && !fifo_empty;
    assign hs           = m_axis_tvalid && m_axis_tready;
    assign rem_one      = (rem == LEN_BITS'(1));
    assign busy         = (state != IDLE);

    always_comb begin
        state_n = state;
        rem_n   = rem;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_len != '0) begin
                        rem_n   = cfg_len;
                        state_n = RUN;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (pop) begin
                    rem_n = rem - LEN_BITS'(1);
                    if (rem_one) begin
                        state_n = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (hs && m_axis_tlast) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                rem_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            done  <= done_n;
        end
    end

    // Output register: a pop reloads it on the same edge as a handshake,
    // so back-to-back beats flow at one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (pop) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= fifo_data;
            m_axis_tlast  <= rem_one;
        end else if (hs) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

endmodule

// File: doc/fifo_axis_tx.md
# fifo_axis_tx

Downstream drain stage for the ring `fifo`: pops words from the FIFO's first-word-fall-through read port and emits them as an AXI-Stream master packet of programmable length with `tlast` on the final beat. Sits between the FIR output FIFO and the AXI-Stream output port. Contains a one-entry output register so that `tdata`, `tvalid` and `tlast` are fully registered, and it sustains one beat per cycle.

## Interface
- `WIDTH`, 32, data width; must match the FIFO `WIDTH`.
- `LEN_BITS`, 12, width of the packet-length field; maximum packet length is 2^LEN_BITS-1 beats.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO `data_out`; valid whenever `fifo_empty`=0.
- `fifo_r_ready`  out  1  FIFO `r_ready`; combinational. A pop occurs on any edge where `fifo_r_ready`=1 and `fifo_empty`=0.
- `cfg_start`  in  1  one-cycle start pulse.
- `cfg_len`  in  LEN_BITS  packet length in beats; sampled only when `cfg_start` is accepted.
- `busy`  out  1  high while a packet is in progress.
- `done`  out  1  one-cycle pulse when a packet completes.
- `m_axis_tvalid`  out  1  AXI-Stream valid.
- `m_axis_tready`  in  1  AXI-Stream ready.
- `m_axis_tdata`  out  WIDTH  AXI-Stream data.
- `m_axis_tlast`  out  1  high on the final beat of the packet.

## Operation
- States:
  - IDLE: waiting for a start pulse.
  - RUN: popping the FIFO; remaining-beat counter `rem` is nonzero.
  - FLUSH: all beats have been popped; waiting for the last beat to be accepted.
- IDLE:
  - If `cfg_start`=1 and `cfg_len`≠0: load `rem`←`cfg_len` and go to RUN.
  - If `cfg_start`=1 and `cfg_len`=0: stay in IDLE and pulse `done` on the next cycle. No beats are sent.
- `cfg_start` in RUN or FLUSH is ignored. It is not queued.
- Pop rule: `fifo_r_ready` = (state==RUN) & (!`m_axis_tvalid` | `m_axis_tready`). It is 0 in IDLE and FLUSH.
- On a pop:
  - `m_axis_tdata`←`fifo_data`, `m_axis_tvalid`←1.
  - `m_axis_tlast`←(`rem`==1).
  - `rem`←`rem`-1.
  - If `rem` was 1, go to FLUSH.
- On a handshake (`tvalid` & `tready`) with no pop on the same edge: `m_axis_tvalid`←0.
  - `m_axis_tdata` keeps its last value.
  - `m_axis_tlast`←0.
- While `m_axis_tvalid`=1 and `m_axis_tready`=0, `tdata` and `tlast` are held stable and no pop occurs (AXI rule).
- `m_axis_tvalid` never deasserts without a handshake.
- FLUSH: on a handshake with `tlast`=1, go to IDLE and pulse `done` on the next cycle.
- Empty FIFO in RUN:
  - No pop occurs and the state does not change.
  - `tvalid` drops after any pending beat is accepted.
  - Bubbles inside a packet are legal.
- `busy` = (state≠IDLE); registered, equivalent to the state encoding.
- Width rules:
  - `rem` is LEN_BITS wide and never underflows.
  - Beats sent per packet equal `cfg_len` exactly.

## Timing
- Reset values:
  - State IDLE, `rem`=0.
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0.
  - `busy`=0, `done`=0, `fifo_r_ready`=0.
- Start to first pop: `cfg_start` at edge N, so RUN is entered at N. The first pop can occur at edge N+1. The word is on `tdata` with `tvalid`=1 after edge N+1.
- FIFO pop to `tdata`: one cycle latency.
- Throughput: with `tready`=1 and a non-empty FIFO, one beat per cycle. The output register is reloaded on the same edge as the handshake.
- `done`: asserted for exactly one cycle, the cycle after the edge where the `tlast` beat handshakes. `busy` falls on that same edge.
- Back-to-back packets: a new `cfg_start` is accepted in the cycle `done` is high.
- Asynchronous reset mid-packet:
  - All outputs return to their reset values immediately.
  - The partially sent packet is abandoned with no `tlast`.
  - FIFO contents are the FIFO's concern.

## Test plan
- Basic packet: FIFO holds 0xA,0xB,0xC,0xD; `cfg_len`=4; `tready`=1 -> `tdata` shows A,B,C,D on 4 consecutive cycles, `tlast` only on D, `done` pulses 1 cycle after D, `busy` is 0 after.
- Backpressure: `cfg_len`=3, `tready` held 0 for 3 cycles after the first beat -> beat 1 held stable, `fifo_r_ready`=0, no extra pops; output resumes 2,3 in order with `tlast` on 3.
- Underflow bubbles: `cfg_len`=3, FIFO receives one word every 4 cycles -> `tvalid` drops between beats, exactly 3 beats, `tlast` on the 3rd, `done` after it.
- Edge lengths:
  - `cfg_len`=1 -> a single beat with `tlast`=1.
  - `cfg_len`=0 -> no `tvalid`, `done` one cycle after start, `busy` stays 0.
- Restart and reset:
  - `cfg_start` pulsed while busy -> ignored, beat count unchanged.
  - `rst_n` asserted after beat 2 of 4 -> `tvalid`, `tlast`, `busy` go to 0 immediately; a new packet of 2 then completes normally.
